// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Optional borrow-in port is enabled by defining SUB_BORROW_IN_EN.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_N = 4;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, with borrow out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~A & Bin) | (B & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (Diff = A - B, LSB first) with start/busy/done handshake.
// Define SUB_BORROW_IN_EN to add a Bin port used as the initial borrow.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
`ifdef SUB_BORROW_IN_EN
    input  logic         Bin,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
    output logic         flagB,
    output logic         flagZ,
    output logic         flagN,
    output logic         flagV
);

    localparam int             IW       = $clog2(N);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    state_t         r_state;
    state_t         w_next_state;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_partial;
    logic           r_bor;
    logic [IW-1:0]  r_idx;
    logic           w_d;
    logic           w_bout;
    logic           w_last;
    logic           w_bor_init;
    logic [N-1:0]   w_diff_final;

`ifdef SUB_BORROW_IN_EN
    assign w_bor_init = Bin;
`else
    assign w_bor_init = 1'b0;
`endif

    full_subtractor u_fs (
        .A    (r_a[r_idx]),
        .B    (r_b[r_idx]),
        .Bin  (r_bor),
        .D    (w_d),
        .Bout (w_bout)
    );

    assign w_last = (r_state == SHIFT) && (r_idx == LAST_IDX);

    // The final bit is not yet in r_partial on the last SHIFT edge, so splice it in.
    always_comb begin
        w_diff_final        = r_partial;
        w_diff_final[N-1]   = w_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SHIFT;
            SHIFT:   if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SHIFT);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_partial <= '0;
            r_bor     <= 1'b0;
            r_idx     <= '0;
            Diff      <= '0;
            flagB     <= 1'b0;
            flagZ     <= 1'b0;
            flagN     <= 1'b0;
            flagV     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_bor     <= w_bor_init;
                        r_idx     <= '0;
                        r_partial <= '0;
                    end
                end
                SHIFT: begin
                    r_partial[r_idx] <= w_d;
                    r_bor            <= w_bout;
                    r_idx            <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        Diff  <= w_diff_final;
                        flagB <= w_bout;
                        flagZ <= (w_diff_final == '0);
                        flagN <= w_d;
                        flagV <= (r_a[N-1] != r_b[N-1]) && (w_d != r_a[N-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed and random operands against an arithmetic model.
module tb_serial_subtractor;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] diff;
        logic         b;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [N-1:0] Diff;
    logic         flagB;
    logic         flagZ;
    logic         flagN;
    logic         flagV;

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_pushed   = 0;
    int   n_done     = 0;
    exp_t exp_q[$];

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef SUB_BORROW_IN_EN
        .Bin   (Bin),
`endif
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .flagB (flagB),
        .flagZ (flagZ),
        .flagN (flagN),
        .flagV (flagV)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^N; borrow is "result went negative".
    function automatic exp_t model(input int a, input int b, input int bin);
        exp_t         e;
        int           raw;
        logic [N-1:0] av;
        logic [N-1:0] bv;
        raw    = a - b - bin;
        av     = a[N-1:0];
        bv     = b[N-1:0];
        e.diff = N'((raw + (2 << N)) % (1 << N));
        e.b    = (raw < 0);
        e.z    = (e.diff == 0);
        e.n    = e.diff[N-1];
        e.v    = (av[N-1] != bv[N-1]) && (e.diff[N-1] != av[N-1]);
        return e;
    endfunction

    task automatic push_exp(input int a, input int b, input int bin);
        exp_q.push_back(model(a, b, bin));
        n_pushed++;
    endtask

    // Monitor: compare each done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            check("busy_at_done", busy, 0);
            if (exp_q.size() == 0) begin
                check("done_without_op", done, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff",  Diff,  e.diff);
                check("flagB", flagB, e.b);
                check("flagZ", flagZ, e.z);
                check("flagN", flagN, e.n);
                check("flagV", flagV, e.v);
            end
        end
    end

    // Accept one operation, scramble the inputs afterwards, and measure busy length.
    task automatic do_op(input int a, input int b, input int bin);
        int cyc;
        @(negedge clk);
        A = a[N-1:0]; B = b[N-1:0]; Bin = bin[0]; start = 1'b1;
        push_exp(a, b, bin);
        @(negedge clk);
        start = 1'b0;
        A = N'($urandom); B = N'($urandom); Bin = 1'($urandom);
        cyc = 0;
        while (!done && cyc < 3 * N) begin
            if (busy) cyc++;
            @(negedge clk);
        end
        check("busy_cycles", cyc, N);
        @(negedge clk);
        check("done_single_pulse", done, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        #12;
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_diff",  Diff, 0);
        check("rst_flags", {flagB, flagZ, flagN, flagV}, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(7, 3, 0);
        do_op(3, 7, 0);
        do_op(5, 5, 0);
        do_op(7, 8, 0);
        do_op(8, 1, 0);
        do_op(0, 15, 0);
        do_op(15, 15, 0);

        // start held through SHIFT with changed operands: first result must use 9-2.
        @(negedge clk);
        A = 4'd9; B = 4'd2; start = 1'b1;
        push_exp(9, 2, 0);
        @(negedge clk);
        A = 4'd1; B = 4'd1;
        cyc = 0;
        while (!done && cyc < 3 * N) begin
            cyc++;
            @(negedge clk);
        end
        check("hold_done_seen", done, 1);
        @(negedge clk);
        push_exp(1, 1, 0);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 3 * N) begin
            cyc++;
            @(negedge clk);
        end
        check("hold_second_done", done, 1);
        @(negedge clk);

        // Reset two cycles into SHIFT aborts with no done pulse.
        do_op(7, 3, 0);
        @(negedge clk);
        A = 4'd10; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy",  busy, 0);
        check("abort_done",  done, 0);
        check("abort_diff",  Diff, 0);
        check("abort_flags", {flagB, flagZ, flagN, flagV}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 3) @(negedge clk);
        do_op(6, 1, 0);

`ifdef SUB_BORROW_IN_EN
        do_op(5, 2, 1);
        do_op(0, 0, 1);
        do_op(8, 0, 1);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef SUB_BORROW_IN_EN
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
`else
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
`endif
        end

        repeat (N + 3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("done_count", n_done, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned/two's-complement subtractor: computes Diff = A - B one bit per clock, LSB first.
- Uses a 1-bit full-subtractor stage and a registered borrow.
- Sits beside the ripple adder in the lab datapath as its inverse operation.
- Produces arithmetic flags (borrow, zero, negative, overflow) and uses a start/busy/done handshake.

Parameters:
- N, 4, operand and result width in bits (N >= 2).

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request a subtraction; sampled only in IDLE.
- A, input, N, minuend; latched when start is accepted.
- B, input, N, subtrahend; latched when start is accepted.
- busy, output, 1, high while bits are being processed.
- done, output, 1, single-cycle pulse when Diff and the flags are valid.
- Diff, output, N, result A - B modulo 2^N.
- flagB, output, 1, borrow out; 1 when A < B unsigned.
- flagZ, output, 1, 1 when Diff == 0.
- flagN, output, 1, equals Diff[N-1].
- flagV, output, 1, signed overflow: (A[N-1] != B[N-1]) && (Diff[N-1] != A[N-1]).

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, Diff=0, all flags=0; internal operand, borrow, bit-index and partial-result registers cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge k latches A and B, sets borrow=0, idx=0, partial=0, and moves to SHIFT. busy=1 from edge k.
- SHIFT: each edge processes bit idx:
  - d = a^b^bor
  - bor' = (~a&b) | (~a&bor) | (b&bor)
  - d is written to partial[idx]; idx increments.
- End of SHIFT: the edge that processes bit N-1 (edge k+N) loads Diff and all flags from the final values, moves to DONE, and drops busy.
- DONE: done=1 for exactly one cycle; unconditional return to IDLE on the next edge.
- Latency: done is high in the cycle following edge k+N, i.e. N cycles after acceptance. Minimum start-to-start spacing is N+2 cycles.
- Output hold: Diff and flags hold their values until the next result load. They do not change during SHIFT; they update only on entry to DONE.
- start while busy or in DONE: ignored; latched operands are unaffected. start must be high in IDLE to be accepted. If start is held high continuously, a new operation begins on the first edge in IDLE.
- Input changes: changes to A and B after acceptance have no effect.
- idx width: $clog2(N) bits. idx wraps to 0 on entry to DONE.
- Reset mid-SHIFT: aborts the operation, no done pulse, outputs return to 0.

Optional Feature:
- Macro: SUB_BORROW_IN_EN.
- Defined: adds input port Bin (1 bit). Bin is latched with A and B at acceptance and used as the initial borrow, so Diff = A - B - Bin. This allows chaining multi-word subtraction; flagB reflects the final borrow including Bin.
- Undefined: no Bin port; initial borrow is fixed at 0.

Decomposition:
- Package sub_pkg:
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, DONE}
  - localparam DEFAULT_N = 4
- Sub-module full_subtractor:
  - Combinational, inputs A, B, Bin; outputs D, Bout.
  - Instantiated once in the serial datapath.

Test Plan:
- N=4, A=7, B=3, start pulse -> done exactly 4 cycles after acceptance; Diff=4, flagB=0, flagZ=0, flagN=0, flagV=0; busy high for exactly 4 cycles.
- A=3, B=7 -> Diff=4'b1100 (12), flagB=1, flagN=1, flagV=0, flagZ=0.
- A=5, B=5 -> Diff=0, flagZ=1, flagB=0, flagN=0, flagV=0.
- A=4'b0111, B=4'b1000 -> Diff=4'b1111, flagV=1, flagB=1, flagN=1. Then A=4'b1000, B=4'b0001 -> Diff=4'b0111, flagV=1, flagB=0.
- Accept A=9, B=2; hold start and drive A=1, B=1 during SHIFT -> first result Diff=7. Exactly one done pulse occurs per accepted operation. No acceptance happens while busy=1.
- Assert rst two cycles into SHIFT -> all outputs 0 immediately, no done pulse. Next op A=6, B=1 -> Diff=5, flagB=0, flagN=0, flagV=0. With SUB_BORROW_IN_EN defined and Bin=1, A=5, B=2 -> Diff=2, flagB=0; A=0, B=0, Bin=1 -> Diff=15, flagB=1.
